// File: rtl/latency_memory.sv
// latency_memory
// Word-organised memory responder with a fixed response latency. It serves a
// single read/write/resp master: a request is captured in IDLE, the access
// happens LATENCY edges later, and resp pulses for one cycle. It also flags
// protocol violations and out-of-range addresses, and counts completions.
//
// Ports
//   clk       clock, all state changes on the rising edge
//   rst       asynchronous active-high reset (memory contents are retained)
//   read      read request, held by the master until resp
//   write     write request, held by the master until resp
//   wmask     per-byte write enables, bit i enables byte i
//   address   byte address, low log2(DATA_WIDTH/8) bits ignored
//   wdata     write data
//   resp      one-cycle completion pulse
//   rdata     read data, valid while resp is high, held otherwise
//   busy      high while a request is outstanding
//   error     sticky protocol / range error flag
//   rd_count  completed reads, saturating
//   wr_count  completed writes, saturating
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for exactly one of read/write
// BUSY  | request latched, latency counter running down to 0
// RESP  | resp high for one cycle, inputs ignored, completion counted
module latency_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    read,
    input  logic                    write,
    input  logic [DATA_WIDTH/8-1:0] wmask,
    input  logic [ADDR_WIDTH-1:0]   address,
    input  logic [DATA_WIDTH-1:0]   wdata,
    output logic                    resp,
    output logic [DATA_WIDTH-1:0]   rdata,
    output logic                    busy,
    output logic                    error,
    output logic [31:0]             rd_count,
    output logic [31:0]             wr_count
);

    localparam int BYTES  = DATA_WIDTH / 8;
    localparam int OFFSET = (BYTES > 1) ? $clog2(BYTES) : 0;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]          LAT_M1  = 8'(LATENCY - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_X = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_RESP
    } state_t;

    state_t state, state_nxt;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [7:0]            cnt;
    logic                  lat_write;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [BYTES-1:0]      lat_mask;
    logic [DATA_WIDTH-1:0] lat_wdata;
    logic                  lat_oor;

    logic [ADDR_WIDTH-1:0] live_idx;
    logic                  live_oor;

    logic                  capture;
    logic                  both_req;
    logic                  violation;

    // Access performed on this edge, either from latched values (end of BUSY)
    // or straight from the inputs when LATENCY=1 skips BUSY entirely.
    logic                  commit;
    logic                  com_write;
    logic                  com_oor;
    logic [IDX_W-1:0]      com_idx;
    logic [BYTES-1:0]      com_mask;
    logic [DATA_WIDTH-1:0] com_wdata;

    assign live_idx = address >> OFFSET;
    assign live_oor = ({1'b0, live_idx} >= DEPTH_X);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        both_req  = 1'b0;
        violation = 1'b0;
        case (state)
            S_IDLE: begin
                if (read ^ write) begin
                    capture   = 1'b1;
                    state_nxt = (LATENCY == 1) ? S_RESP : S_BUSY;
                end else if (read && write) begin
                    both_req = 1'b1;
                end
            end
            S_BUSY: begin
                violation = (lat_write ? (!write || read) : (!read || write))
                            || (address != lat_addr);
                if (cnt == 8'd0) begin
                    state_nxt = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_comb begin
        commit    = 1'b0;
        com_write = lat_write;
        com_oor   = lat_oor;
        com_idx   = IDX_W'(lat_addr >> OFFSET);
        com_mask  = lat_mask;
        com_wdata = lat_wdata;
        if (state == S_BUSY && cnt == 8'd0) begin
            commit = 1'b1;
        end else if (capture && LATENCY == 1) begin
            commit    = 1'b1;
            com_write = write;
            com_oor   = live_oor;
            com_idx   = IDX_W'(live_idx);
            com_mask  = wmask;
            com_wdata = wdata;
        end
    end

    // Array has no reset so contents survive rst; rst still blocks a commit.
    always_ff @(posedge clk) begin
        if (!rst && commit && com_write && !com_oor) begin
            for (int b = 0; b < BYTES; b++) begin
                if (com_mask[b]) begin
                    mem[com_idx][8*b +: 8] <= com_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt       <= 8'd0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_mask  <= '0;
            lat_wdata <= '0;
            lat_oor   <= 1'b0;
            rdata     <= '0;
            error     <= 1'b0;
            rd_count  <= 32'd0;
            wr_count  <= 32'd0;
        end else begin
            if (capture) begin
                lat_write <= write;
                lat_addr  <= address;
                lat_mask  <= wmask;
                lat_wdata <= wdata;
                lat_oor   <= live_oor;
                cnt       <= LAT_M1;
            end else if (state == S_BUSY && cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end

            if (commit && !com_write) begin
                rdata <= com_oor ? '0 : mem[com_idx];
            end

            if (both_req || (capture && live_oor) || violation) begin
                error <= 1'b1;
            end

            if (state == S_RESP) begin
                if (lat_write) begin
                    if (wr_count != 32'hFFFF_FFFF) begin
                        wr_count <= wr_count + 32'd1;
                    end
                end else begin
                    if (rd_count != 32'hFFFF_FFFF) begin
                        rd_count <= rd_count + 32'd1;
                    end
                end
            end
        end
    end

    assign resp = (state == S_RESP);
    assign busy = (state != S_IDLE);

endmodule

// File: doc/latency_memory.md
Name: latency_memory

Overview:
- Parametrised, synthesizable successor to the single-cycle behavioural memory responder used by the processor benches.
- Serves one `read`/`write`/`resp` master port with configurable data width, depth and fixed response latency.
- Adds protocol-violation detection, out-of-range detection and completion counters.
- Sits between the processor's memory port and the bench, so multicycle and cache designs can be exercised against non-zero memory latency.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; multiple of 8.
- ADDR_WIDTH, 32, byte-address width.
- DEPTH, 1024, number of DATA_WIDTH words stored.
- LATENCY, 3, cycles from request capture to resp; legal range 1..255.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- read  input  1  read request, held by master until resp.
- write  input  1  write request, held by master until resp.
- wmask  input  DATA_WIDTH/8  byte enables for writes; bit i enables byte i.
- address  input  ADDR_WIDTH  byte address; low log2(DATA_WIDTH/8) bits ignored.
- wdata  input  DATA_WIDTH  write data.
- resp  output  1  one-cycle completion pulse.
- rdata  output  DATA_WIDTH  read data, valid while resp is high.
- busy  output  1  high while a request is outstanding (BUSY or RESP).
- error  output  1  sticky protocol/range error flag.
- rd_count  output  32  completed reads, saturating.
- wr_count  output  32  completed writes, saturating.

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - resp=0, busy=0, error=0, rdata=0, rd_count=0, wr_count=0, latency counter=0.
  - Memory array is not cleared; contents are retained across reset.
- Word index is address >> log2(DATA_WIDTH/8). An index >= DEPTH is out-of-range.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - On an edge with exactly one of read/write high: latch op, address, wmask and wdata; load counter with LATENCY-1.
  - Go to BUSY if LATENCY>1; go directly to RESP if LATENCY=1.
  - read and write both high: set error, capture nothing, stay IDLE.
- BUSY:
  - Each edge decrements the counter.
  - On the edge where the counter is 0, go to RESP.
  - Write commits to the array on that same edge: bytes with latched wmask=1 are updated, others are unchanged. wmask=0 completes as a no-op write.
  - Read loads rdata from the array on that same edge.
- Resp timing: resp is high for exactly the one cycle following the LATENCY-th rising edge after the capture edge. Example: LATENCY=3, capture at edge 0, resp high between edges 3 and 4.
- RESP:
  - Inputs are ignored.
  - Next edge always goes to IDLE and drops resp. A request still asserted on that edge is not captured, which gives the master one cycle to deassert or present a new request.
  - On the RESP->IDLE edge, rd_count or wr_count increments unless already 0xFFFFFFFF.
- rdata holds its last value outside resp cycles.
- Out-of-range request:
  - Full latency and resp are still produced.
  - A read returns rdata=0; a write is dropped.
  - error is set on the capture edge; the counter still increments.
- Protocol violation: any edge in BUSY where the latched op's request line is low, the other request line is high, or address differs from the latched value. Response:
  - Sets error.
  - Transaction continues using the latched values; no abort.
- error clears only on rst.
- Reset during BUSY or RESP:
  - Pending write is discarded (array unchanged) and no resp is issued.
  - Returns to IDLE and may capture a new request on the first edge after rst deasserts.

Test Plan:
- Reset values: assert rst mid-simulation with random inputs -> resp=0, busy=0, error=0, rdata=0, rd_count=0, wr_count=0 immediately, without waiting for a clock edge.
- Latency and counters, LATENCY=3:
  - Write 0xDEADBEEF to 0x00000010 with wmask=4'hF -> resp high exactly 3 edges after capture, for 1 cycle.
  - Read of 0x00000010 -> rdata=0xDEADBEEF during resp; wr_count=1, rd_count=1.
- Byte masks:
  - Write 0x11223344 full-mask to 0x20, then 0xAABBCCDD with wmask=4'b0101 -> read of 0x20 returns 0x11BB33DD.
  - A read of 0x21 also returns 0x11BB33DD, since the low address bits are ignored.
- Range and request errors:
  - DEPTH=1024, read of address 0x00001000 -> resp after LATENCY, rdata=0, error=1, rd_count increments.
  - read=write=1 in IDLE -> no resp, error=1.
- Protocol violation: change address during BUSY of a read -> error=1; rdata is still the data at the original latched address.
- Reset mid-operation, LATENCY=5:
  - Assert rst 2 cycles after capturing a write of 0xCAFEF00D to 0x40 -> no resp; a later read of 0x40 returns the prior contents.
  - A new read issued right after rst deasserts completes normally.
